// File: rtl/parity_frame_tx.sv
// Serial transmitter for parity-framed words: it re-checks parity when a word
// is accepted, then sends start bit, 8 bits LSB-first and stop bit.
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic             par_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_nx;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_idx_nx;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nx;
  logic             tx_nx;
  logic             busy_nx;
  logic             frame_done_nx;
  logic             par_err_nx;
  logic [ERR_W-1:0] err_cnt_nx;
  logic             bit_end;
  logic             word_bad;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign word_bad  = (^din) ^ PARITY_ODD;
  assign din_ready = (state == S_IDLE);

  // State and registered outputs; tx goes high asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      par_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_cnt_nx;
      bit_idx    <= bit_idx_nx;
      shreg      <= shreg_nx;
      tx         <= tx_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
      par_err    <= par_err_nx;
      err_cnt    <= err_cnt_nx;
    end
  end

  // Next-state and next-output decode; tx_nx is the level for the coming cycle.
  always_comb begin
    state_nx      = state;
    baud_cnt_nx   = baud_cnt;
    bit_idx_nx    = bit_idx;
    shreg_nx      = shreg;
    tx_nx         = tx;
    busy_nx       = busy;
    frame_done_nx = 1'b0;
    par_err_nx    = par_err;
    err_cnt_nx    = err_cnt;

    case (state)
      S_IDLE: begin
        tx_nx = 1'b1;
        if (din_valid) begin
          shreg_nx    = din;
          par_err_nx  = word_bad;
          if (word_bad && (err_cnt != '1)) begin
            err_cnt_nx = err_cnt + ERR_W'(1);
          end
          baud_cnt_nx = '0;
          bit_idx_nx  = '0;
          tx_nx       = 1'b0;
          busy_nx     = 1'b1;
          state_nx    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          tx_nx       = shreg[0];
          state_nx    = S_DATA;
        end else begin
          baud_cnt_nx = baud_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_idx == IDX_LAST) begin
            bit_idx_nx = '0;
            tx_nx      = 1'b1;
            state_nx   = S_STOP;
          end else begin
            // Next data bit is the one that lands in bit 0 after this shift.
            bit_idx_nx = bit_idx + IDX_W'(1);
            shreg_nx   = {1'b0, shreg[7:1]};
            tx_nx      = shreg[1];
          end
        end else begin
          baud_cnt_nx = baud_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_cnt_nx   = '0;
          busy_nx       = 1'b0;
          frame_done_nx = 1'b1;
          state_nx      = S_IDLE;
        end else begin
          baud_cnt_nx = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: frame scoreboard on a default instance, plus
// small-counter and odd-parity instances checked from vector tables.
module tb_parity_frame_tx;

  localparam int unsigned C_A = 4;
  localparam int unsigned C_B = 2;

  typedef struct {
    logic [7:0] din;
    logic       par;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       rst_a, valid_a, ready_a, tx_a, busy_a, fd_a, pe_a;
  logic [7:0] din_a, ec_a;
  // Instance B: 4-bit error counter
  logic       rst_b, valid_b, ready_b, tx_b, busy_b, fd_b, pe_b;
  logic [7:0] din_b;
  logic [3:0] ec_b;
  // Instance C: odd parity
  logic       rst_c, valid_c, ready_c, tx_c, busy_c, fd_c, pe_c;
  logic [7:0] din_c, ec_c;

  parity_frame_tx #(.CLKS_PER_BIT(C_A), .PARITY_ODD(1'b0), .ERR_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .par_err(pe_a), .err_cnt(ec_a));

  parity_frame_tx #(.CLKS_PER_BIT(C_B), .PARITY_ODD(1'b0), .ERR_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .par_err(pe_b), .err_cnt(ec_b));

  parity_frame_tx #(.CLKS_PER_BIT(C_B), .PARITY_ODD(1'b1), .ERR_W(8)) dut_c (
    .clk(clk), .reset(rst_c), .din(din_c), .din_valid(valid_c), .din_ready(ready_c),
    .tx(tx_c), .busy(busy_c), .frame_done(fd_c), .par_err(pe_c), .err_cnt(ec_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic p, input logic [7:0] c);
    vec_t v;
    v.din = d;
    v.par = p;
    v.cnt = c;
    return v;
  endfunction

  // Expected tx level for each cycle of a frame, one bit per cycle.
  function automatic logic [63:0] frame_bits(input logic [7:0] w);
    logic [63:0] v;
    int b;
    v = '0;
    for (int i = 0; i < 10 * C_A; i++) begin
      b = i / C_A;
      if (b == 0)      v[i] = 1'b0;
      else if (b == 9) v[i] = 1'b1;
      else             v[i] = w[b-1];
    end
    return v;
  endfunction

  vec_t exp_q[$];
  vec_t cur;
  bit   have_exp  = 1'b0;
  bit   abort_a   = 1'b0;
  bit   check_gap = 1'b0;
  bit   ctrl_bad  = 1'b0;
  int   fcyc      = 0;
  int   idle_cnt  = 0;
  logic [63:0] cap = '0;

  // Frame monitor for instance A: pops an expectation when a frame starts.
  always @(negedge clk) begin
    if (busy_a) begin
      if (fcyc == 0) begin
        cap = '0;
        if (check_gap) begin
          check("idle_gap", 64'(idle_cnt), 64'd1);
          check_gap = 1'b0;
        end
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          check("unexpected_frame", 64'(busy_a), 64'd0);
        end else begin
          cur = exp_q.pop_front();
          have_exp = 1'b1;
          check($sformatf("par_err_%02h", cur.din), 64'(pe_a), 64'(cur.par));
          check($sformatf("err_cnt_%02h", cur.din), 64'(ec_a), 64'(cur.cnt));
        end
      end
      if (fcyc < 64) cap[fcyc] = tx_a;
      if (ready_a || fd_a) ctrl_bad = 1'b1;
      fcyc++;
      idle_cnt = 0;
    end else begin
      if (fcyc != 0) begin
        if (abort_a) begin
          abort_a = 1'b0;
        end else if (have_exp) begin
          check($sformatf("frame_bits_%02h", cur.din), cap, frame_bits(cur.din));
          check("frame_len", 64'(fcyc), 64'(10 * C_A));
          check("frame_done_pulse", 64'(fd_a), 64'd1);
          check("ready_low_in_frame", 64'(ctrl_bad), 64'd0);
        end
        fcyc = 0;
        ctrl_bad = 1'b0;
      end else if (fd_a) begin
        check("frame_done_extra", 64'(fd_a), 64'd0);
      end
      idle_cnt++;
    end
  end

  task automatic send_a(input vec_t v);
    int n = 0;
    while (!ready_a && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait_a", 64'(ready_a), 64'd1);
    din_a = v.din;
    valid_a = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((exp_q.size() != 0 || fcyc != 0 || busy_a) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("idle_wait_a", 64'(n < 1000), 64'd1);
  endtask

  task automatic accept_b(input logic [7:0] d);
    int n = 0;
    while (!ready_b && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait_b", 64'(ready_b), 64'd1);
    din_b = d;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic accept_c(input logic [7:0] d);
    int n = 0;
    while (!ready_c && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait_c", 64'(ready_c), 64'd1);
    din_c = d;
    valid_c = 1'b1;
    @(posedge clk); #1;
    valid_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t vec_a[2];
  vec_t vec_b[17];
  vec_t vec_c[2];

  initial begin
    int n;

    vec_a[0] = mk(8'h55, 1'b0, 8'd0);
    vec_a[1] = mk(8'hD5, 1'b1, 8'd1);
    for (int i = 0; i < 17; i++) vec_b[i] = mk(8'h01, 1'b1, (i + 1 > 15) ? 8'd15 : 8'(i + 1));
    vec_c[0] = mk(8'h01, 1'b0, 8'd0);
    vec_c[1] = mk(8'h00, 1'b1, 8'd1);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_tx", 64'(tx_a), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_frame_done", 64'(fd_a), 64'd0);
    check("rst_par_err", 64'(pe_a), 64'd0);
    check("rst_err_cnt", 64'(ec_a), 64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    check("rst_err_cnt_b", 64'(ec_b), 64'd0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(posedge clk); #1;

    // Single frames: good and bad parity
    for (int i = 0; i < 2; i++) begin
      send_a(vec_a[i]);
      wait_idle_a();
    end

    // Back-to-back with din_valid held; din changes while busy
    din_a = 8'h55;
    valid_a = 1'b1;
    exp_q.push_back(mk(8'h55, 1'b0, 8'd1));
    @(posedge clk); #1;
    din_a = 8'h2A;
    exp_q.push_back(mk(8'h2A, 1'b1, 8'd2));
    @(negedge clk); #1;
    check_gap = 1'b1;
    n = 0;
    while (!ready_a && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("b2b_ready", 64'(ready_a), 64'd1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    wait_idle_a();
    check("gap_seen", 64'(check_gap), 64'd0);

    // Reset mid-frame
    abort_a = 1'b1;
    send_a(mk(8'h55, 1'b0, 8'd2));
    repeat (14) @(posedge clk);
    @(negedge clk); #2;
    rst_a = 1'b0;
    #1;
    check("abort_tx", 64'(tx_a), 64'd1);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_ready", 64'(ready_a), 64'd1);
    check("abort_err_cnt", 64'(ec_a), 64'd0);
    check("abort_par_err", 64'(pe_a), 64'd0);
    @(posedge clk); #1;
    check("abort_tx_held", 64'(tx_a), 64'd1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("abort_seen", 64'(abort_a), 64'd0);
    send_a(mk(8'h55, 1'b0, 8'd0));
    wait_idle_a();

    // Saturating 4-bit error counter
    for (int i = 0; i < 17; i++) begin
      accept_b(vec_b[i].din);
      check($sformatf("sat_par_err_%0d", i), 64'(pe_b), 64'(vec_b[i].par));
      check($sformatf("sat_err_cnt_%0d", i), 64'(ec_b), 64'(vec_b[i].cnt));
    end

    // Odd parity mode
    for (int i = 0; i < 2; i++) begin
      accept_c(vec_c[i].din);
      check($sformatf("odd_par_err_%0d", i), 64'(pe_c), 64'(vec_c[i].par));
      check($sformatf("odd_err_cnt_%0d", i), 64'(ec_c), 64'(vec_c[i].cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
